fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of decode.

---
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, talks to a variable-latency
// instruction memory, parks words across load-use stalls and discards responses made stale by redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_from_hazard,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] target, target_nx;
  logic [31:0] hold_buf, hold_buf_nx;
  logic [31:0] instr_nx, pc4_nx;
  logic        valid_nx;

  function automatic logic [31:0] inc4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  assign imem_req  = (state != HOLD);
  assign imem_addr = pc;

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    target_nx   = target;
    hold_buf_nx = hold_buf;
    instr_nx    = if_id_instr;
    pc4_nx      = if_id_pc4;
    valid_nx    = if_id_valid;
    case (state)
      FETCH: begin
        if (imem_ready) begin
          if (redirect_valid) begin
            pc_nx    = redirect_pc;
            instr_nx = NOP_INSTR;
            pc4_nx   = 32'd0;
            valid_nx = 1'b0;
          end else if (we_from_hazard) begin
            instr_nx = imem_rdata;
            pc4_nx   = inc4(pc);
            valid_nx = 1'b1;
            pc_nx    = inc4(pc);
          end else begin
            hold_buf_nx = imem_rdata;
            state_nx    = HOLD;
          end
        end else if (redirect_valid) begin
          // The in-flight request must still complete; remember where to go afterwards.
          target_nx = redirect_pc;
          instr_nx  = NOP_INSTR;
          pc4_nx    = 32'd0;
          valid_nx  = 1'b0;
          state_nx  = DRAIN;
        end else if (we_from_hazard) begin
          instr_nx = NOP_INSTR;
          pc4_nx   = 32'd0;
          valid_nx = 1'b0;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nx       = redirect_pc;
          hold_buf_nx = 32'd0;
          instr_nx    = NOP_INSTR;
          pc4_nx      = 32'd0;
          valid_nx    = 1'b0;
          state_nx    = FETCH;
        end else if (we_from_hazard) begin
          instr_nx = hold_buf;
          pc4_nx   = inc4(pc);
          valid_nx = 1'b1;
          pc_nx    = inc4(pc);
          state_nx = FETCH;
        end
      end
      DRAIN: begin
        instr_nx = NOP_INSTR;
        pc4_nx   = 32'd0;
        valid_nx = 1'b0;
        if (redirect_valid)
          target_nx = redirect_pc;
        if (imem_ready) begin
          // Youngest redirect wins, even one arriving alongside the completion.
          pc_nx    = redirect_valid ? redirect_pc : target;
          state_nx = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      target      <= 32'd0;
      hold_buf    <= 32'd0;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      target      <= target_nx;
      hold_buf    <= hold_buf_nx;
      if_id_instr <= instr_nx;
      if_id_pc4   <= pc4_nx;
      if_id_valid <= valid_nx;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: a variable-latency memory model, directed stall/redirect
// sequences, and a second instance exercising PC wrap and reset during a pending request.
module tb_fetch_stage;

  localparam logic [31:0] K = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we_from_hazard = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_ready = 1'b0;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;

  logic        reset2 = 1'b1;
  logic        we2 = 1'b1;
  logic        redir2 = 1'b0;
  logic [31:0] redir_pc2 = 32'd0;
  logic        req2;
  logic [31:0] addr2, rdata2, instr2, pc4_2;
  logic        ready2 = 1'b0;
  logic        valid2;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic mon_we, mon_rst;

  int          wait_n = 0;
  int          cnt = 0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .we_from_hazard(we_from_hazard),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset2), .we_from_hazard(we2),
    .redirect_valid(redir2), .redirect_pc(redir_pc2),
    .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
    .imem_ready(ready2), .if_id_instr(instr2), .if_id_pc4(pc4_2),
    .if_id_valid(valid2)
  );

  assign rdata2 = addr2 ^ K;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.instr = a ^ K;
    e.pc4   = a + 32'd4;
    q.push_back(e);
  endtask

  task automatic step(input logic w, input logic r, input logic [31:0] t);
    we_from_hazard = w;
    redirect_valid = r;
    redirect_pc    = t;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic r, input logic rd);
    reset2 = r;
    ready2 = rd;
    @(posedge clk);
    #1;
  endtask

  // Memory model: answers after wait_n idle cycles, data = addr ^ K
  always @(negedge clk) begin
    if (reset) begin
      imem_ready = 1'b0;
      cnt        = 0;
      prev_pend  = 1'b0;
    end else begin
      if (prev_pend) chk("addr_stable", imem_addr, prev_addr);
      if (imem_req && cnt >= wait_n) begin
        imem_ready = 1'b1;
        imem_rdata = imem_addr ^ K;
        cnt        = 0;
      end else begin
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        if (imem_req) cnt++;
      end
      prev_pend = imem_req && !imem_ready;
      prev_addr = imem_addr;
    end
  end

  // Monitor: a fresh IF/ID load is a valid word captured on an advancing cycle
  always @(posedge clk) begin
    mon_we  = we_from_hazard;
    mon_rst = reset;
    #1;
    if (!mon_rst && mon_we && if_id_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got instr=%h pc4=%h, required no delivery", if_id_instr, if_id_pc4);
      end else begin
        mon_e = q.pop_front();
        chk("sb_instr", if_id_instr, mon_e.instr);
        chk("sb_pc4", if_id_pc4, mon_e.pc4);
      end
    end
  end

  initial begin
    // Reset state
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, 32'd0);
    chk("rst_pc4", if_id_pc4, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'd0);
    reset = 1'b0;

    // Zero-wait streaming
    for (int i = 0; i < 4; i++) begin
      push(32'(i * 4));
      step(1'b1, 1'b0, 32'd0);
      chk("t1_valid", {31'd0, if_id_valid}, 32'd1);
    end

    // Load-use stall at pc=0x10
    step(1'b0, 1'b0, 32'd0);
    chk("t3_frozen_pc4", if_id_pc4, 32'h10);
    chk("t3_frozen_instr", if_id_instr, 32'hC0DE_000C);
    chk("t3_hold_req", {31'd0, imem_req}, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk("t3_frozen_pc4b", if_id_pc4, 32'h10);
    chk("t3_hold_reqb", {31'd0, imem_req}, 32'd0);
    push(32'h10);
    step(1'b1, 1'b0, 32'd0);
    push(32'h14);
    step(1'b1, 1'b0, 32'd0);

    // Two wait cycles per instruction
    wait_n = 2;
    for (int i = 0; i < 2; i++) begin
      push(32'h18 + 32'(i * 4));
      step(1'b1, 1'b0, 32'd0);
      chk("t2_wait1_valid", {31'd0, if_id_valid}, 32'd0);
      chk("t2_wait1_addr", imem_addr, 32'h18 + 32'(i * 4));
      step(1'b1, 1'b0, 32'd0);
      chk("t2_wait2_valid", {31'd0, if_id_valid}, 32'd0);
      step(1'b1, 1'b0, 32'd0);
    end

    // Redirect during a pending request at 0x20
    wait_n = 3;
    step(1'b1, 1'b0, 32'd0);
    chk("t4_wait_valid", {31'd0, if_id_valid}, 32'd0);
    step(1'b1, 1'b1, 32'h100);
    chk("t4_redir_valid", {31'd0, if_id_valid}, 32'd0);
    chk("t4_drain_addr", imem_addr, 32'h20);
    step(1'b1, 1'b0, 32'd0);
    chk("t4_drain_valid", {31'd0, if_id_valid}, 32'd0);
    chk("t4_drain_req", {31'd0, imem_req}, 32'd1);
    step(1'b1, 1'b0, 32'd0);
    chk("t4_dropped_valid", {31'd0, if_id_valid}, 32'd0);
    chk("t4_new_addr", imem_addr, 32'h100);
    wait_n = 0;
    push(32'h100);
    step(1'b1, 1'b0, 32'd0);

    // Redirect while holding a parked word
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h200);
    chk("t5_valid", {31'd0, if_id_valid}, 32'd0);
    chk("t5_instr", if_id_instr, 32'd0);
    chk("t5_addr", imem_addr, 32'h200);
    chk("t5_req", {31'd0, imem_req}, 32'd1);
    push(32'h200);
    step(1'b1, 1'b0, 32'd0);
    push(32'h204);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h300);
    chk("t5b_valid", {31'd0, if_id_valid}, 32'd0);
    chk("t5b_addr", imem_addr, 32'h300);
    push(32'h300);
    step(1'b1, 1'b0, 32'd0);
    we_from_hazard = 1'b0;

    // PC wrap and reset during a pending request
    step2(1'b1, 1'b0);
    chk("t6_rst_addr", addr2, 32'hFFFF_FFFC);
    chk("t6_rst_valid", {31'd0, valid2}, 32'd0);
    step2(1'b0, 1'b1);
    chk("t6_wrap_pc4", pc4_2, 32'd0);
    chk("t6_wrap_valid", {31'd0, valid2}, 32'd1);
    chk("t6_wrap_instr", instr2, 32'hFFFF_FFFC ^ K);
    chk("t6_wrap_addr", addr2, 32'd0);
    step2(1'b0, 1'b0);
    chk("t6_wait_valid", {31'd0, valid2}, 32'd0);
    chk("t6_wait_addr", addr2, 32'd0);
    step2(1'b1, 1'b1);
    chk("t6_midrst_addr", addr2, 32'hFFFF_FFFC);
    chk("t6_midrst_valid", {31'd0, valid2}, 32'd0);
    chk("t6_midrst_instr", instr2, 32'd0);
    step2(1'b0, 1'b0);
    chk("t6_late_addr", addr2, 32'hFFFF_FFFC);
    chk("t6_late_valid", {31'd0, valid2}, 32'd0);
    step2(1'b0, 1'b1);
    chk("t6_refetch_pc4", pc4_2, 32'd0);
    chk("t6_refetch_valid", {31'd0, valid2}, 32'd1);

    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
